// File: rtl/mem_stage_wb_pkg.sv
// Shared encodings for the MEM stage: access sizes, writeback selects, FSM states
// and the MEM/WB register payload.
package mem_stage_wb_pkg;

    localparam logic [2:0] SzB  = 3'b000;
    localparam logic [2:0] SzH  = 3'b001;
    localparam logic [2:0] SzW  = 3'b010;
    localparam logic [2:0] SzBu = 3'b100;
    localparam logic [2:0] SzHu = 3'b101;

    typedef enum logic [1:0] {
        WbMem = 2'b00,
        WbAlu = 2'b01,
        WbPc4 = 2'b10,
        WbImm = 2'b11
    } wb_sel_e;

    typedef enum logic {
        StIdle  = 1'b0,
        StSplit = 1'b1
    } state_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic        reg_wen;
        logic [1:0]  wb_sel;
        logic [31:0] alu;
        logic [31:0] mem_data;
        logic [8:0]  pc_plus4;
        logic [31:0] imm;
        logic [8:0]  pc;
        logic        pc_sel;
    } wb_t;

    // Byte mask of an access at offset 0; all-zero marks an illegal size code.
    function automatic logic [3:0] size_mask(input logic [2:0] sz);
        unique case (sz)
            SzB, SzBu: size_mask = 4'b0001;
            SzH, SzHu: size_mask = 4'b0011;
            SzW:       size_mask = 4'b1111;
            default:   size_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_wb_dmem_bank.sv
// Data RAM as four byte-lane arrays: per-lane write enable, asynchronous read,
// one shared word index.
module mem_stage_wb_dmem_bank #(
    parameter int unsigned DEPTH = 256,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] idx_i,
    input  logic [3:0]    we_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] lane_q [DEPTH];

        always_ff @(posedge clk) begin
            if (we_i[l]) begin
                lane_q[idx_i] <= wdata_i[8*l +: 8];
            end
        end

        assign rdata_o[8*l +: 8] = lane_q[idx_i];
    end

endmodule

// File: rtl/mem_stage_wb.sv
// MEM stage with MEM/WB register. Misaligned accesses take two cycles: the lower
// word in IDLE (upstream stalled), the next word in SPLIT.
module mem_stage_wb
    import mem_stage_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  PC_MEM,
    input  logic [8:0]  PCPlusF_MEM,
    input  logic [31:0] WD_cut_MEM,
    input  logic [31:0] Imm_MEM,
    input  logic [4:0]  Rd_MEM,
    input  logic [31:0] ALU_o_MEM,
    input  logic        MemRW_MEM,
    input  logic        RegWEn_MEM,
    input  logic        PCsel_MEM,
    input  logic [1:0]  WBSel_MEM,
    input  logic [2:0]  WordSizeSel_MEM,
    output logic        stall_o,
    output logic [4:0]  Rd_WB,
    output logic        RegWEn_WB,
    output logic [1:0]  WBSel_WB,
    output logic [31:0] ALU_o_WB,
    output logic [31:0] MemData_WB,
    output logic [8:0]  PCPlusF_WB,
    output logic [31:0] Imm_WB,
    output logic [8:0]  PC_WB,
    output logic        PCsel_WB
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_e      state_q, state_d;
    logic [31:0] hold_q, hold_d;
    wb_t         wb_q, wb_d;

    logic [AW-1:0] idx, bank_idx;
    logic [1:0]    off;
    logic [3:0]    mask;
    logic [7:0]    lanes;
    logic [63:0]   st_span, ld_span, ld_shift;
    logic [31:0]   raw, load_ext, rdata, wdata;
    logic [3:0]    we;
    logic          misal, split;

    assign idx      = ALU_o_MEM[AW+1:2];
    assign off      = ALU_o_MEM[1:0];
    assign split    = (state_q == StSplit);
    assign bank_idx = split ? idx + 1'b1 : idx;
    assign mask     = size_mask(WordSizeSel_MEM);
    assign misal    = ((mask == 4'b0011) && off[0]) || ((mask == 4'b1111) && (off != 2'b00));

    // An access spans at most two words; lanes[7:4] belong to word i+1.
    assign lanes   = {4'b0000, mask} << off;
    assign st_span = {32'h0, WD_cut_MEM} << {off, 3'b000};
    assign we      = (MemRW_MEM && !rst) ? (split ? lanes[7:4] : lanes[3:0]) : 4'b0000;
    assign wdata   = split ? st_span[63:32] : st_span[31:0];

    assign ld_span  = split ? {rdata, hold_q} : {32'h0, rdata};
    assign ld_shift = ld_span >> {off, 3'b000};
    assign raw      = ld_shift[31:0];

    always_comb begin
        load_ext = 32'h0;
        unique case (WordSizeSel_MEM)
            SzB:     load_ext = {{24{raw[7]}}, raw[7:0]};
            SzBu:    load_ext = {24'h0, raw[7:0]};
            SzH:     load_ext = {{16{raw[15]}}, raw[15:0]};
            SzHu:    load_ext = {16'h0, raw[15:0]};
            SzW:     load_ext = raw;
            default: load_ext = 32'h0;
        endcase
    end

    mem_stage_wb_dmem_bank #(
        .DEPTH(DEPTH)
    ) u_dmem_bank (
        .clk    (clk),
        .idx_i  (bank_idx),
        .we_i   (we),
        .wdata_i(wdata),
        .rdata_o(rdata)
    );

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        stall_o = 1'b0;
        wb_d    = '{
            rd:       Rd_MEM,
            reg_wen:  RegWEn_MEM,
            wb_sel:   WBSel_MEM,
            alu:      ALU_o_MEM,
            mem_data: load_ext,
            pc_plus4: PCPlusF_MEM,
            imm:      Imm_MEM,
            pc:       PC_MEM,
            pc_sel:   PCsel_MEM
        };
        if (split) begin
            state_d = StIdle;
        end else if (misal) begin
            stall_o = !rst;
            state_d = StSplit;
            hold_d  = rdata;
            wb_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            hold_q  <= 32'h0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            wb_q    <= wb_d;
        end
    end

    assign Rd_WB      = wb_q.rd;
    assign RegWEn_WB  = wb_q.reg_wen;
    assign WBSel_WB   = wb_q.wb_sel;
    assign ALU_o_WB   = wb_q.alu;
    assign MemData_WB = wb_q.mem_data;
    assign PCPlusF_WB = wb_q.pc_plus4;
    assign Imm_WB     = wb_q.imm;
    assign PC_WB      = wb_q.pc;
    assign PCsel_WB   = wb_q.pc_sel;

endmodule
